// File: rtl/branch_predict_resolve_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predict_resolve_if
//  Purpose  : Bundles the decode-lookup, EX-resolve and performance-counter
//             signals of the branch resolution unit.
//  Modports : master - pipeline side (drives lookup PC and EX-stage fields,
//                      receives prediction, redirect and perf counters)
//             slave  - branch_predict_resolve unit
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_predict_resolve_if #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 32
);
    // Decode-stage lookup
    logic [XLEN-1:0]   lookup_pc;
    logic              pred_taken;

    // EX-stage instruction
    logic              validE;
    logic              stallE;
    logic              BranchE;
    logic              jalE;
    logic              jalrE;
    logic [2:0]        funct3E;
    logic              Z_flag;
    logic              N_flag;
    logic              C_flag;
    logic              V_flag;
    logic [XLEN-1:0]   pcE;
    logic              pred_takenE;
    logic [XLEN-1:0]   branch_targetE;
    logic [XLEN-1:0]   jalr_targetE;

    // Resolution results
    logic [1:0]        PCSrc;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;

    // Performance counters
    logic [PERF_W-1:0] branch_cnt;
    logic [PERF_W-1:0] mispred_cnt;

    modport master (
        output lookup_pc, validE, stallE, BranchE, jalE, jalrE, funct3E,
               Z_flag, N_flag, C_flag, V_flag, pcE, pred_takenE,
               branch_targetE, jalr_targetE,
        input  pred_taken, PCSrc, redirect, redirect_pc, branch_cnt,
               mispred_cnt
    );

    modport slave (
        input  lookup_pc, validE, stallE, BranchE, jalE, jalrE, funct3E,
               Z_flag, N_flag, C_flag, V_flag, pcE, pred_takenE,
               branch_targetE, jalr_targetE,
        output pred_taken, PCSrc, redirect, redirect_pc, branch_cnt,
               mispred_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_predict_resolve.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predict_resolve
//  Purpose  : EX-stage branch resolution with an integrated bimodal
//             predictor (table of 2-bit saturating counters).
//  Ports    : clk   - clock, all state on rising edge
//             rst_n - synchronous active-low reset
//             bus   - branch_predict_resolve_if.slave:
//                       lookup_pc -> pred_taken         (decode lookup)
//                       EX fields -> PCSrc / redirect / redirect_pc
//                       branch_cnt, mispred_cnt         (perf counters)
//  Params   : BHT_ENTRIES must be a power of two, >= 2.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_predict_resolve #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CNT_INIT    = 2'b01,
    parameter int         PERF_W      = 32
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    branch_predict_resolve_if.slave bus
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // Function selects on funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        bht_q [BHT_ENTRIES];
    logic [PERF_W-1:0] branch_cnt_q,  branch_cnt_d;
    logic [PERF_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // ------------------------------------------------------------------
    // Decode-side lookup: reads registered state only, so a same-cycle
    // update to the same index is not visible until the next cycle.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;

    assign lookup_idx     = bus.lookup_pc[IDX_W+1:2];
    assign upd_idx        = bus.pcE[IDX_W+1:2];
    assign bus.pred_taken = bht_q[lookup_idx][1];

    // ------------------------------------------------------------------
    // Branch outcome from ALU flags (flags come from rs1 - rs2)
    // ------------------------------------------------------------------
    logic taken;
    logic f3_legal;

    always_comb begin
        taken    = 1'b0;
        f3_legal = 1'b1;
        case (bus.funct3E)
            F3_BEQ:  taken = bus.Z_flag;
            F3_BNE:  taken = ~bus.Z_flag;
            F3_BLT:  taken = bus.N_flag ^ bus.V_flag;
            F3_BGE:  taken = ~(bus.N_flag ^ bus.V_flag);
            F3_BLTU: taken = ~bus.C_flag;
            F3_BGEU: taken = bus.C_flag;
            default: f3_legal = 1'b0;
        endcase
    end

    // A conditional branch only counts when no jump outranks it.
    logic is_cond;
    logic act;
    logic train;

    assign is_cond = bus.BranchE & f3_legal & ~bus.jalE & ~bus.jalrE;
    assign act     = bus.validE & ~bus.stallE;
    assign train   = act & is_cond;

    // ------------------------------------------------------------------
    // PC source and redirect
    // ------------------------------------------------------------------
    logic [1:0]      pcsrc_w;
    logic            redirect_w;
    logic [XLEN-1:0] redirect_pc_w;
    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = bus.pcE + XLEN'(4);

    always_comb begin
        pcsrc_w       = 2'b00;
        redirect_w    = 1'b0;
        redirect_pc_w = '0;
        if (bus.validE) begin
            if (bus.jalE) begin
                pcsrc_w       = 2'b10;
                redirect_w    = 1'b1;
                redirect_pc_w = bus.branch_targetE;
            end else if (bus.jalrE) begin
                pcsrc_w       = 2'b11;
                redirect_w    = 1'b1;
                redirect_pc_w = {bus.jalr_targetE[XLEN-1:1], 1'b0};
            end else if (is_cond) begin
                pcsrc_w       = taken ? 2'b01 : 2'b00;
                redirect_w    = taken ^ bus.pred_takenE;
                redirect_pc_w = taken ? bus.branch_targetE : pc_plus4;
            end
        end
    end

    assign bus.PCSrc       = pcsrc_w;
    assign bus.redirect    = redirect_w;
    assign bus.redirect_pc = redirect_pc_w;

    // ------------------------------------------------------------------
    // Counter training (saturating 2-bit)
    // ------------------------------------------------------------------
    logic [1:0] ctr_cur;
    logic [1:0] ctr_d;

    assign ctr_cur = bht_q[upd_idx];

    always_comb begin
        ctr_d = ctr_cur;
        if (taken) begin
            if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'b01;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters (saturating at all-ones)
    // ------------------------------------------------------------------
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (train) begin
            if (branch_cnt_q != '1)
                branch_cnt_d = branch_cnt_q + PERF_W'(1);
            if (redirect_w && (mispred_cnt_q != '1))
                mispred_cnt_d = mispred_cnt_q + PERF_W'(1);
        end
    end

    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;

    // ------------------------------------------------------------------
    // State registers. The table is a flop array so the whole of it
    // returns to CNT_INIT in a single reset edge; reset wins over any
    // update presented in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CNT_INIT;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (train) begin
                bht_q[upd_idx] <= ctr_d;
            end
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Only the index bits of the PCs are used by the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.lookup_pc[XLEN-1:IDX_W+2], bus.lookup_pc[1:0],
                              bus.pcE[XLEN-1:IDX_W+2], bus.pcE[1:0]};

endmodule
`default_nettype wire

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- EX-stage branch resolution unit with an integrated bimodal predictor.
- Resolves conditional branches, JAL and JALR from ALU flags and funct3, and keeps a BHT_ENTRIES-deep table of 2-bit saturating counters.
- Decode reads a prediction from the table. EX compares the actual outcome against the prediction carried down the pipe, raises redirect/flush, trains the table and maintains performance counters.
- Replaces the purely combinational PCSrc generator.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_ENTRIES, 64, counter table depth; power of 2, ≥2. IDX_W = log2(BHT_ENTRIES).
- CNT_INIT, 2'b01, reset value of every counter (weakly not-taken).
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- lookup_pc  in  XLEN  PC of the instruction in decode.
- pred_taken  out  1  combinational: MSB of counter[lookup_pc[IDX_W+1:2]].
- validE  in  1  EX holds a real instruction (not a bubble).
- stallE  in  1  EX is held this cycle.
- BranchE  in  1  conditional branch in EX.
- jalE  in  1  JAL in EX.
- jalrE  in  1  JALR in EX.
- funct3E  in  3  branch funct3.
- Z_flag, N_flag, C_flag, V_flag  in  1 each  ALU flags from rs1-rs2.
- pcE  in  XLEN  PC of the EX instruction.
- pred_takenE  in  1  prediction made for this instruction in decode.
- branch_targetE  in  XLEN  pcE+immB, or pcE+immJ for JAL.
- jalr_targetE  in  XLEN  rs1+immI (raw sum).
- PCSrc  out  2  00 PC+4, 01 branch, 10 JAL, 11 JALR.
- redirect  out  1  combinational: fetch must load redirect_pc and flush D/E.
- redirect_pc  out  XLEN  combinational corrected PC.
- branch_cnt  out  PERF_W  resolved conditional branches.
- mispred_cnt  out  PERF_W  mispredicted conditional branches.

Behaviour:
- Qualifier: act = validE & ~stallE. All outputs are forced to 0 (PCSrc=00, redirect=0, redirect_pc=0) when validE=0. With validE=1 and stallE=1, the outputs are still driven but no state changes.
- Outcome (taken) by funct3:
  - 000 BEQ: Z.
  - 001 BNE: ~Z.
  - 100 BLT: N^V (signed-correct).
  - 101 BGE: ~(N^V).
  - 110 BLTU: ~C.
  - 111 BGEU: C.
  - 010/011 are illegal: not-taken, no redirect, no training, no counting.
- PCSrc priority: jalE > jalrE > BranchE. For a branch, PCSrc=01 iff taken.
- Redirect rules:
  - JAL: redirect=1, redirect_pc = branch_targetE.
  - JALR: redirect=1, redirect_pc = jalr_targetE with bit0 cleared.
  - Legal conditional branch: redirect = taken ^ pred_takenE. redirect_pc = branch_targetE if taken, else pcE+4 (mod 2^XLEN).
- Training: on act & BranchE & legal funct3 & ~jalE & ~jalrE, counter[pcE[IDX_W+1:2]] updates next edge:
  - Taken: increment, saturating at 11.
  - Not-taken: decrement, saturating at 00.
- Read during same-cycle write to the same index returns the old value (no bypass).
- Perf counters, updated under the same condition as training:
  - branch_cnt += 1.
  - mispred_cnt += 1 when redirect.
  - Both saturate at all-ones.
- Reset: when rst_n=0 at a clock edge, all counters are set to CNT_INIT and the perf counters to 0, taking priority over any update that cycle. The table reset completes in that single edge (flop array, not RAM). A reset mid-stream discards an in-flight update.
- Stall: a stallE=1 cycle never trains or counts, so a branch held N cycles updates exactly once, on its act cycle.

Test Plan:
- Reset, then lookup_pc=0x100 -> pred_taken=0; branch_cnt=mispred_cnt=0.
- BEQ, pcE=0x100, Z=1, pred_takenE=0, target 0x140 -> PCSrc=01, redirect=1, redirect_pc=0x140. Next cycle lookup 0x100 -> pred_taken=1; mispred_cnt=1.
- Saturation and hysteresis: at one index, 3 taken BNE (Z=0) to saturate at 11, then 1 not-taken -> pred stays 1. A second not-taken -> pred 0. Predicted-correct cases give redirect=0.
- Signed compare: BLT with N=0,V=1 -> taken. BGE with N=1,V=1 -> taken. BLTU with C=1 -> not-taken, redirect_pc=pcE+4 when pred_takenE=1.
- JALR with jalr_targetE=0x2003 -> PCSrc=11, redirect_pc=0x2002, branch_cnt unchanged. Illegal funct3 010 with BranchE=1 -> PCSrc=00, no counter change.
- Hazards: same-index lookup and update in one cycle -> old prediction. A branch stalled 3 cycles trains once. rst_n low during an act cycle -> no update, table at CNT_INIT.
